// File: rtl/led_pwm_pkg.sv
// Shared types, register offsets and CH field layout for the LED controller.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_PWM   = 2'd2,
        LED_BLINK = 2'd3
    } led_mode_e;

    localparam logic [7:0] LED_PRESCALE = 8'h00;
    localparam logic [7:0] LED_LEVEL    = 8'h04;
    localparam logic [7:0] LED_CH_BASE  = 8'h10;

    localparam int unsigned CH_MODE_LSB = 0;
    localparam int unsigned CH_DUTY_LSB = 8;
    localparam int unsigned CH_HALF_LSB = 16;

    function automatic logic [31:0] ch_word(led_mode_e mode, logic [7:0] duty, logic [7:0] half);
        logic [31:0] w;
        w = '0;
        w[CH_MODE_LSB +: 2] = mode;
        w[CH_DUTY_LSB +: 8] = duty;
        w[CH_HALF_LSB +: 8] = half;
        return w;
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone pipelined bus bundle shared by the peripheral slaves.
interface wb_if (input logic clk);
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [3:0]  sel;
    logic        ack;
    logic        err;
    logic        stall;

    modport slave  (input clk, rst, cyc, stb, we, adr, dat_i, sel,
                    output dat_o, ack, err, stall);
    modport master (input clk, dat_o, ack, err, stall,
                    output rst, cyc, stb, we, adr, dat_i, sel);
endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: blink counter/phase and the registered LED drive.
module led_pwm_channel
    import led_pwm_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tick,
    input  logic [7:0] pwm_cnt,
    input  led_mode_e mode,
    input  logic [7:0] duty,
    input  logic [7:0] half,
    input  logic      restart,
    output logic      led
);

    logic [7:0] cnt;
    logic [7:0] last;
    logic       phase;
    logic       nxt;

    // Half-period 0 is treated as 1 tick.
    always_comb last = (half == '0) ? '0 : half - 8'd1;

    always_comb begin
        nxt = 1'b0;
        case (mode)
            LED_OFF:   nxt = 1'b0;
            LED_ON:    nxt = 1'b1;
            LED_PWM:   nxt = (pwm_cnt < duty);
            LED_BLINK: nxt = phase;
            default:   nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
            led   <= 1'b0;
        end else begin
            led <= nxt;
            if (restart) begin
                cnt   <= '0;
                phase <= 1'b1;
            end else if (tick) begin
                // >= keeps a shortened half-period from running the counter all the way round
                if (cnt >= last) begin
                    cnt   <= '0;
                    phase <= ~phase;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/led_pwm.sv
// Wishbone LED controller: register file, tick prescaler, shared PWM counter.
module led_pwm
    import led_pwm_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned PSW = 16
)(
    input  logic           clk,
    input  logic           rst_n,
    output logic [NCH-1:0] led,
    wb_if.slave            wb
);

    logic            valid;
    logic            wr;
    logic [5:0]      idx;
    logic [5:0]      ch_idx;
    logic            is_pre;
    logic            is_lvl;
    logic            is_ch;
    logic            hit;
    logic [31:0]     rdata;
    logic [NCH-1:0]  restart;

    logic [PSW-1:0]  prescale;
    logic [PSW-1:0]  psc_cnt;
    logic            tick;
    logic [7:0]      pwm_cnt;

    led_mode_e       mode_r [NCH];
    logic [7:0]      duty_r [NCH];
    logic [7:0]      half_r [NCH];

    logic            unused_ok;
    assign unused_ok = ^{wb.clk, wb.rst, wb.sel, wb.adr, wb.dat_i};
    assign wb.stall  = 1'b0;

    always_comb begin
        valid  = wb.cyc & wb.stb;
        wr     = valid & wb.we;
        idx    = wb.adr[7:2];
        ch_idx = idx - LED_CH_BASE[7:2];
        is_pre = (idx == LED_PRESCALE[7:2]);
        is_lvl = (idx == LED_LEVEL[7:2]);
        is_ch  = (idx >= LED_CH_BASE[7:2]) && (32'(ch_idx) < NCH);
        hit    = is_pre | is_lvl | is_ch;
    end

    always_comb begin
        rdata   = '0;
        restart = '0;
        if (is_pre) begin
            rdata[PSW-1:0] = prescale;
        end else if (is_lvl) begin
            rdata[NCH-1:0] = led;
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            if (is_ch && 32'(ch_idx) == i) begin
                rdata      = ch_word(mode_r[i], duty_r[i], half_r[i]);
                restart[i] = wr;
            end
        end
    end

    assign tick = (psc_cnt == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            // A PRESCALE write only restarts the count; it never adds a tick.
            if (tick || (wr && is_pre))
                psc_cnt <= '0;
            else
                psc_cnt <= psc_cnt + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                mode_r[i] <= LED_OFF;
                duty_r[i] <= '0;
                half_r[i] <= '0;
            end
        end else begin
            if (wr && is_pre)
                prescale <= wb.dat_i[PSW-1:0];
            for (int unsigned i = 0; i < NCH; i++) begin
                if (restart[i]) begin
                    mode_r[i] <= led_mode_e'(wb.dat_i[CH_MODE_LSB +: 2]);
                    duty_r[i] <= wb.dat_i[CH_DUTY_LSB +: 8];
                    half_r[i] <= wb.dat_i[CH_HALF_LSB +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.ack   <= 1'b0;
            wb.err   <= 1'b0;
            wb.dat_o <= '0;
        end else begin
            wb.ack   <= valid & hit;
            wb.err   <= valid & ~hit;
            wb.dat_o <= (valid && hit) ? rdata : '0;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        led_pwm_channel u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .pwm_cnt (pwm_cnt),
            .mode    (mode_r[g]),
            .duty    (duty_r[g]),
            .half    (half_r[g]),
            .restart (restart[g]),
            .led     (led[g])
        );
    end

endmodule

// File: tb/tb_led_pwm.sv
// Self-checking bench for led_pwm: vector table, scoreboarded bus responses, timed LED sequences.
module tb_led_pwm;
    import led_pwm_pkg::*;

    localparam int unsigned NCH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] led;

    wb_if bus (.clk(clk));

    led_pwm #(.NCH(NCH), .PSW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .led   (led),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        string       name;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        exp_err;
        logic [31:0] exp_dat;
        string       name;
    } vec_t;

    resp_t sb[$];
    vec_t  vecs[$];
    int    checks = 0;
    int    failures = 0;
    logic  bs[40];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called right after a negedge; holds the beat for one cycle.
    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic eerr, input logic [31:0] edat, input string name);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = we;
        bus.adr   = adr;
        bus.dat_i = dat;
        bus.sel   = 4'hF;
        sb.push_back('{eerr, edat, name});
        @(negedge clk);
    endtask

    task automatic idle();
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
    endtask

    task automatic measure_pwm(input string name, input int exp_high);
        logic s[256];
        int hi;
        int rises;
        hi = 0;
        rises = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 256; k++) begin
            s[k] = led[0];
            if (s[k]) hi++;
            @(negedge clk);
        end
        for (int k = 0; k < 256; k++)
            if (s[k] && !s[(k + 255) % 256]) rises++;
        check({name, "_high"}, hi, exp_high);
        check({name, "_runs"}, rises, (exp_high == 0) ? 0 : 1);
    endtask

    // Response monitor: every accepted beat must answer exactly one cycle later.
    initial begin : monitor
        logic  had;
        resp_t r;
        forever begin
            @(posedge clk);
            had = bus.cyc && bus.stb && rst_n;
            #1;
            if (had) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: got beat with ack=%b err=%b expected none queued", bus.ack, bus.err);
                end else begin
                    r = sb.pop_front();
                    check({r.name, "_ack"}, bus.ack, !r.err);
                    check({r.name, "_err"}, bus.err, r.err);
                    check({r.name, "_dat"}, bus.dat_o, r.dat);
                end
            end else if (rst_n) begin
                check("idle_resp", {bus.ack, bus.err}, '0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int ntrans;
        int last_t;
        bit waited;

        bus.rst   = 1'b0;
        bus.sel   = 4'hF;
        bus.adr   = '0;
        bus.dat_i = '0;
        idle();

        vecs.push_back('{1'b0, 32'h04,  32'h0,        1'b0, 32'h0,        "rd_level0"});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        1'b0, 32'h0,        "rd_ch0_0"});
        vecs.push_back('{1'b0, 32'h00,  32'h0,        1'b0, 32'h0,        "rd_pre0"});
        vecs.push_back('{1'b1, 32'h00,  32'hDEAD0005, 1'b0, 32'h0,        "wr_pre"});
        vecs.push_back('{1'b0, 32'h00,  32'h0,        1'b0, 32'h5,        "rd_pre5"});
        vecs.push_back('{1'b1, 32'h1C,  32'hFFFFFF00, 1'b0, 32'h0,        "wr_ch3"});
        vecs.push_back('{1'b0, 32'h1C,  32'h0,        1'b0, 32'h00FFFF00, "rd_ch3"});
        vecs.push_back('{1'b1, 32'h20,  32'hFFFFFFFF, 1'b1, 32'h0,        "wr_ch4_err"});
        vecs.push_back('{1'b0, 32'h20,  32'h0,        1'b1, 32'h0,        "rd_ch4_err"});
        vecs.push_back('{1'b1, 32'h08,  32'hFFFFFFFF, 1'b1, 32'h0,        "wr_08_err"});
        vecs.push_back('{1'b0, 32'h0C,  32'h0,        1'b1, 32'h0,        "rd_0c_err"});
        vecs.push_back('{1'b0, 32'h1C,  32'h0,        1'b0, 32'h00FFFF00, "rd_ch3_kept"});
        vecs.push_back('{1'b0, 32'h00,  32'h0,        1'b0, 32'h5,        "rd_pre_kept"});
        vecs.push_back('{1'b1, 32'h04,  32'hF,        1'b0, 32'h0,        "wr_level_ign"});
        vecs.push_back('{1'b0, 32'h104, 32'h0,        1'b0, 32'h0,        "rd_level_alias"});
        vecs.push_back('{1'b1, 32'h1C,  32'h0,        1'b0, 32'h00FFFF00, "wr_ch3_clr"});
        vecs.push_back('{1'b1, 32'h00,  32'h0,        1'b0, 32'h5,        "wr_pre_clr"});
        vecs.push_back('{1'b0, 32'h1C,  32'h0,        1'b0, 32'h0,        "rd_ch3_clr"});

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_led", led, '0);
        check("rst_ack", bus.ack, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_dat", bus.dat_o, '0);

        // Table, issued as one back-to-back pipelined burst.
        foreach (vecs[i])
            drive(vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].exp_err, vecs[i].exp_dat, vecs[i].name);
        idle();
        drain();
        check("table_led", led, '0);

        // CH2 ON: LED follows two edges after the beat.
        drive(1'b1, 32'h18, 32'h1, 1'b0, 32'h0, "ch2_on_wr");
        idle();
        check("ch2_on_early", led, 4'b0000);
        @(negedge clk);
        check("ch2_on_late", led, 4'b0100);
        drive(1'b0, 32'h04, 32'h0, 1'b0, 32'h4, "level_rd");
        idle();
        drain();

        // PWM on CH0 with a tick every clock.
        drive(1'b1, 32'h00, 32'h0,    1'b0, 32'h0, "pwm_pre_wr");
        drive(1'b1, 32'h10, 32'h4002, 1'b0, 32'h0, "pwm64_wr");
        idle();
        measure_pwm("pwm64", 64);
        drive(1'b1, 32'h10, 32'h0002, 1'b0, 32'h4002, "pwm0_wr");
        idle();
        measure_pwm("pwm0", 0);
        drive(1'b1, 32'h10, 32'hFF02, 1'b0, 32'h0002, "pwm255_wr");
        idle();
        measure_pwm("pwm255", 255);
        drive(1'b1, 32'h10, 32'h0, 1'b0, 32'hFF02, "pwm_off_wr");
        idle();
        drain();

        // BLINK on CH1, half-period 3 ticks at 2 clocks/tick.
        drive(1'b1, 32'h00, 32'h1,       1'b0, 32'h0, "blink_pre_wr");
        drive(1'b1, 32'h14, 32'h30003,   1'b0, 32'h0, "blink_wr");
        idle();
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            bs[k] = led[1];
            @(negedge clk);
        end
        check("blink_start", bs[0], 1'b1);
        ntrans = 0;
        last_t = -1;
        for (int k = 1; k < 40; k++) begin
            if (bs[k] != bs[k-1]) begin
                if (last_t >= 0) check("blink_gap", k - last_t, 6);
                last_t = k;
                ntrans++;
            end
        end
        check("blink_toggles", ntrans >= 5, 1'b1);

        // Rewrite at the start of an off half-period: phase must restart at 1.
        waited = 1'b0;
        for (int k = 0; k < 20 && !waited; k++) begin
            if (led[1]) waited = 1'b1;
            else @(negedge clk);
        end
        check("blink_wait_hi", waited, 1'b1);
        waited = 1'b0;
        for (int k = 0; k < 20 && !waited; k++) begin
            @(negedge clk);
            if (!led[1]) waited = 1'b1;
        end
        check("blink_wait_lo", waited, 1'b1);
        drive(1'b1, 32'h14, 32'h30003, 1'b0, 32'h30003, "blink_rewr");
        idle();
        check("blink_rewr_early", led[1], 1'b0);
        @(negedge clk);
        check("blink_restart", led[1], 1'b1);
        repeat (4) @(negedge clk);
        check("blink_restart_hold", led[1], 1'b1);
        drain();

        // Pipelined writes with reset landing on the third beat.
        drive(1'b1, 32'h1C, 32'h1, 1'b0, 32'h0,     "pipe1");
        drive(1'b1, 32'h14, 32'h1, 1'b0, 32'h30003, "pipe2");
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = 1'b1;
        bus.adr   = 32'h10;
        bus.dat_i = 32'h1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_led", led, '0);
        check("async_ack", bus.ack, 1'b0);
        check("async_err", bus.err, 1'b0);
        check("async_dat", bus.dat_o, '0);
        check("pipe_sb_empty", sb.size(), 0);
        @(negedge clk);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_led", led, '0);
        drive(1'b0, 32'h10, 32'h0, 1'b0, 32'h0, "post_rst_ch0");
        drive(1'b0, 32'h14, 32'h0, 1'b0, 32'h0, "post_rst_ch1");
        drive(1'b0, 32'h00, 32'h0, 1'b0, 32'h0, "post_rst_pre");
        idle();
        drain();
        repeat (3) @(negedge clk);
        check("final_led", led, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
